// File: rtl/psys_route_pkg.sv
// Shared definitions for the weight/activation stream router feeding the width packer.
// Holds the arbiter state encoding, packer geometry and source identifiers.
package psys_route_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        PAD  = 2'd2
    } state_t;

    localparam int BEAT_W = 1536;
    localparam int GROUP  = 4;

    localparam logic SRC_WGT = 1'b0;
    localparam logic SRC_ACT = 1'b1;

endpackage

// File: rtl/psys_stream_arbiter.sv
// Packet arbiter between the weight and activation streams in front of the width packer.
// Each packet is padded with zero beats to a whole number of packer groups.
module psys_stream_arbiter #(
    parameter int DATA_W = psys_route_pkg::BEAT_W,
    parameter int GROUP  = psys_route_pkg::GROUP,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tvalid,
    output logic              s0_axis_tready,
    input  logic              s0_axis_tlast,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tvalid,
    output logic              s1_axis_tready,
    input  logic              s1_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              weight_switch,
    input  logic              wgt_prio,
    output logic              grant_src,
    output logic              pad_err,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);
    import psys_route_pkg::state_t;
    import psys_route_pkg::IDLE;
    import psys_route_pkg::PASS;
    import psys_route_pkg::PAD;
    import psys_route_pkg::SRC_WGT;
    import psys_route_pkg::SRC_ACT;

    localparam int BW = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(GROUP - 1);

    state_t            state_reg;
    logic              grant_src_reg;
    logic              last_grant_reg;
    logic              first_reg;
    logic              pad_err_reg;
    logic [BW-1:0]     beat_cnt_reg;
    logic [CNT_W-1:0]  pkt_cnt0_reg;
    logic [CNT_W-1:0]  pkt_cnt1_reg;

    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              at_last_beat;
    logic              xfer;
    logic              grant_next;

    always_comb begin
        sel_data       = (grant_src_reg == SRC_ACT) ? s1_axis_tdata  : s0_axis_tdata;
        sel_valid      = (grant_src_reg == SRC_ACT) ? s1_axis_tvalid : s0_axis_tvalid;
        sel_last       = (grant_src_reg == SRC_ACT) ? s1_axis_tlast  : s0_axis_tlast;
        at_last_beat   = (beat_cnt_reg == LAST_BEAT);

        m_axis_tdata   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;

        case (state_reg)
            PASS: begin
                m_axis_tdata   = sel_data;
                m_axis_tvalid  = sel_valid;
                // A short packet's tlast is swallowed here; PAD emits the real one.
                m_axis_tlast   = sel_last && at_last_beat;
                s0_axis_tready = m_axis_tready && (grant_src_reg == SRC_WGT);
                s1_axis_tready = m_axis_tready && (grant_src_reg == SRC_ACT);
            end
            PAD: begin
                m_axis_tvalid  = 1'b1;
                m_axis_tlast   = at_last_beat;
            end
            default: begin
            end
        endcase

        xfer = m_axis_tvalid && m_axis_tready;

        if (s0_axis_tvalid && s1_axis_tvalid) begin
            grant_next = wgt_prio ? SRC_WGT : ~last_grant_reg;
        end else begin
            grant_next = s0_axis_tvalid ? SRC_WGT : SRC_ACT;
        end
    end

    assign weight_switch = (state_reg == PASS) && (grant_src_reg == SRC_WGT)
                           && (beat_cnt_reg == '0) && first_reg;
    assign grant_src     = grant_src_reg;
    assign pad_err       = pad_err_reg;
    assign pkt_cnt0      = pkt_cnt0_reg;
    assign pkt_cnt1      = pkt_cnt1_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_src_reg  <= SRC_WGT;
            last_grant_reg <= SRC_ACT;
            first_reg      <= 1'b0;
            pad_err_reg    <= 1'b0;
            beat_cnt_reg   <= '0;
            pkt_cnt0_reg   <= '0;
            pkt_cnt1_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        grant_src_reg <= grant_next;
                        beat_cnt_reg  <= '0;
                        first_reg     <= 1'b1;
                        state_reg     <= PASS;
                    end
                end
                PASS: begin
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + BW'(1);
                        first_reg    <= 1'b0;
                        if (sel_last) begin
                            if (at_last_beat) begin
                                if (grant_src_reg == SRC_ACT) begin
                                    pkt_cnt1_reg <= pkt_cnt1_reg + CNT_W'(1);
                                end else begin
                                    pkt_cnt0_reg <= pkt_cnt0_reg + CNT_W'(1);
                                end
                                last_grant_reg <= grant_src_reg;
                                state_reg      <= IDLE;
                            end else begin
                                pad_err_reg <= 1'b1;
                                state_reg   <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    if (xfer) begin
                        beat_cnt_reg <= beat_cnt_reg + BW'(1);
                        if (at_last_beat) begin
                            if (grant_src_reg == SRC_ACT) begin
                                pkt_cnt1_reg <= pkt_cnt1_reg + CNT_W'(1);
                            end else begin
                                pkt_cnt0_reg <= pkt_cnt0_reg + CNT_W'(1);
                            end
                            last_grant_reg <= grant_src_reg;
                            state_reg      <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psys_stream_arbiter.sv
// Self-checking bench for psys_stream_arbiter: packet-level arbitration model plus
// a beat scoreboard, table-driven single-packet vectors and hand-written corner cases.
module tb_psys_stream_arbiter;

    localparam int DW = 32;
    localparam int G  = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic          s0_tvalid, s1_tvalid, s0_tready, s1_tready, s0_tlast, s1_tlast;
    logic          m_tvalid, m_tready, m_tlast;
    logic          ws, wgt_prio, grant, pad_err;
    logic [CW-1:0] cnt0, cnt1;

    logic [DW-1:0] sd [2];
    logic          sv [2];
    logic          sl [2];
    logic          sr [2];

    assign s0_tdata  = sd[0];
    assign s1_tdata  = sd[1];
    assign s0_tvalid = sv[0];
    assign s1_tvalid = sv[1];
    assign s0_tlast  = sl[0];
    assign s1_tlast  = sl[1];
    assign sr[0]     = s0_tready;
    assign sr[1]     = s1_tready;

    always #5 clk = ~clk;

    psys_stream_arbiter #(.DATA_W(DW), .GROUP(G), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tlast(s0_tlast),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tlast(s1_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .weight_switch(ws), .wgt_prio(wgt_prio), .grant_src(grant), .pad_err(pad_err),
        .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
    );

    typedef struct {
        logic [DW-1:0] data;
        bit            last;
        bit            ws;
        bit            src;
    } beat_t;

    typedef struct {
        bit src;
        int len;
        int exp_beats;
        int exp_ws;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // source-side beat queues and packet lists awaiting arbitration planning
    logic [DW-1:0] q_data [2][$];
    bit            q_last [2][$];
    int            pkt_len [2][$];
    logic [DW-1:0] pkt_dat [2][$];
    beat_t         exp_q [$];
    bit            order_q [$];

    // packet-level reference state
    bit m_last_grant;
    int m_cnt [2];
    bit m_pad;

    bit            s_first [2];
    bit            stalled [2];
    bit            gaps;
    int            rdy_mode;
    bit [3:0]      rdy_pat = 4'b1001;
    int            cyc;
    bit            hold_pend;
    logic [DW-1:0] hold_data;
    bit            hold_last;
    bit            prio_watch;
    int            s1_bad;
    bit            gap_watch;
    bit            after_tlast;
    bit            new_pkt;
    int            tlast_cyc;
    int            out_beats, tlast_at, tlast_cnt, ws_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_last_grant = 1'b1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        m_pad = 1'b0;
        for (int s = 0; s < 2; s++) begin
            s_first[s] = 1'b1;
            stalled[s] = 1'b0;
            sv[s] = 1'b0;
            sd[s] = '0;
            sl[s] = 1'b0;
            q_data[s].delete();
            q_last[s].delete();
        end
        exp_q.delete();
        hold_pend = 1'b0;
    endtask

    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (stalled[s]) begin
                // a presented beat is held until it is taken
            end else if (q_data[s].size() > 0) begin
                sv[s] = s_first[s] || !gaps || ($urandom_range(3) != 0);
                sd[s] = q_data[s][0];
                sl[s] = q_last[s][0];
            end else begin
                sv[s] = 1'b0;
                sd[s] = '0;
                sl[s] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(3) != 0);
            default: m_tready = rdy_pat[cyc % 4];
        endcase
    endtask

    task automatic add_pkt(input int s, input int len);
        pkt_len[s].push_back(len);
        for (int b = 0; b < len; b++) pkt_dat[s].push_back($urandom);
    endtask

    // Decides the packet order from the arbitration rules and expands each packet
    // into its padded output beats.
    task automatic load_phase(input bit prio);
        int pi [2];
        int off [2];
        int n [2];
        int len, total;
        bit g;
        beat_t e;
        wgt_prio = prio;
        for (int s = 0; s < 2; s++) begin
            int o = 0;
            n[s] = pkt_len[s].size();
            for (int p = 0; p < n[s]; p++) begin
                for (int b = 0; b < pkt_len[s][p]; b++) begin
                    q_data[s].push_back(pkt_dat[s][o + b]);
                    q_last[s].push_back(b == pkt_len[s][p] - 1);
                end
                o += pkt_len[s][p];
            end
            pi[s] = 0;
            off[s] = 0;
        end
        while (pi[0] < n[0] || pi[1] < n[1]) begin
            if (pi[0] < n[0] && pi[1] < n[1]) g = prio ? 1'b0 : !m_last_grant;
            else g = (pi[0] < n[0]) ? 1'b0 : 1'b1;
            len = pkt_len[g][pi[g]];
            total = ((len + G - 1) / G) * G;
            for (int b = 0; b < total; b++) begin
                e.data = (b < len) ? pkt_dat[g][off[g] + b] : '0;
                e.last = (b == total - 1);
                e.ws   = (g == 1'b0) && (b == 0);
                e.src  = g;
                exp_q.push_back(e);
            end
            off[g] += len;
            pi[g]++;
            m_cnt[g]++;
            m_last_grant = g;
            if (len % G != 0) m_pad = 1'b1;
        end
        for (int s = 0; s < 2; s++) begin
            pkt_len[s].delete();
            pkt_dat[s].delete();
        end
        drive();
    endtask

    task automatic step();
        beat_t e;
        bit    l;
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, hold_data);
            chk("hold_last", m_tlast, hold_last);
        end
        hold_pend = m_tvalid && !m_tready;
        hold_data = m_tdata;
        hold_last = m_tlast;
        chk("dual_ready", s0_tready & s1_tready, 0);
        for (int s = 0; s < 2; s++) if (sr[s]) chk("ready_mirror", m_tready, 1);
        if (prio_watch && sr[1] && q_data[0].size() > 0) s1_bad++;
        if (m_tvalid && m_tready) begin
            chk("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("beat_data", m_tdata, e.data);
                chk("beat_last", m_tlast, e.last);
                chk("beat_ws", ws, e.ws);
                chk("beat_grant", grant, e.src);
            end
            if (new_pkt) order_q.push_back(grant);
            if (gap_watch && after_tlast) chk("idle_gap", cyc - tlast_cyc, 2);
            after_tlast = m_tlast;
            new_pkt = m_tlast;
            if (m_tlast) begin
                tlast_cyc = cyc;
                tlast_cnt++;
            end
            out_beats++;
            if (m_tlast && tlast_at == 0) tlast_at = out_beats;
            if (ws) ws_cnt++;
        end
        for (int s = 0; s < 2; s++) begin
            if (sv[s] && sr[s]) begin
                chk("src_beat_forwarded", m_tvalid && m_tready, 1);
                l = q_last[s].pop_front();
                void'(q_data[s].pop_front());
                s_first[s] = l;
            end
            stalled[s] = sv[s] && !sr[s];
        end
        cyc++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_stats();
        out_beats = 0;
        tlast_at = 0;
        tlast_cnt = 0;
        ws_cnt = 0;
        after_tlast = 1'b0;
        new_pkt = 1'b1;
        order_q.delete();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
        chk("pkt_cnt0", cnt0, m_cnt[0] % (1 << CW));
        chk("pkt_cnt1", cnt1, m_cnt[1] % (1 << CW));
        chk("pad_err", pad_err, m_pad);
    endtask

    task automatic check_reset();
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_s1_tready", s1_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_weight_switch", ws, 0);
        chk("rst_grant_src", grant, 0);
        chk("rst_pad_err", pad_err, 0);
        chk("rst_pkt_cnt0", cnt0, 0);
        chk("rst_pkt_cnt1", cnt1, 0);
    endtask

    vec_t vecs [7];

    initial begin
        int n;
        vecs[0] = '{src: 1'b0, len: 8, exp_beats: 8,  exp_ws: 1};
        vecs[1] = '{src: 1'b1, len: 5, exp_beats: 8,  exp_ws: 0};
        vecs[2] = '{src: 1'b0, len: 1, exp_beats: 4,  exp_ws: 1};
        vecs[3] = '{src: 1'b1, len: 4, exp_beats: 4,  exp_ws: 0};
        vecs[4] = '{src: 1'b0, len: 3, exp_beats: 4,  exp_ws: 1};
        vecs[5] = '{src: 1'b1, len: 9, exp_beats: 12, exp_ws: 0};
        vecs[6] = '{src: 1'b0, len: 2, exp_beats: 4,  exp_ws: 1};

        rst = 1'b1;
        m_tready = 1'b0;
        wgt_prio = 1'b0;
        gaps = 1'b0;
        rdy_mode = 0;
        cyc = 0;
        prio_watch = 1'b0;
        gap_watch = 1'b0;
        s1_bad = 0;
        tlast_cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // round-robin contention straight out of reset: order 0,1,0,1 with one idle cycle
        clear_stats();
        gap_watch = 1'b1;
        for (int p = 0; p < 4; p++) begin
            add_pkt(0, 4);
            add_pkt(1, 4);
        end
        load_phase(1'b0);
        run(200);
        gap_watch = 1'b0;
        chk("rr_pkt_count", order_q.size(), 8);
        for (int i = 0; i < 4 && i < order_q.size(); i++) chk("rr_order", order_q[i], i % 2);
        $display("round-robin: %0d packets forwarded", order_q.size());

        // weight priority: activation stays blocked while weights are pending
        clear_stats();
        prio_watch = 1'b1;
        s1_bad = 0;
        for (int p = 0; p < 3; p++) begin
            add_pkt(0, 4);
            add_pkt(1, 4);
        end
        load_phase(1'b1);
        run(200);
        prio_watch = 1'b0;
        chk("prio_s1_ready", s1_bad, 0);
        for (int i = 0; i < 3 && i < order_q.size(); i++) chk("prio_order", order_q[i], 0);
        $display("weight priority: %0d packets forwarded", order_q.size());

        // table of single packets: padded length, tlast position, weight_switch count
        for (int v = 0; v < 7; v++) begin
            clear_stats();
            add_pkt(vecs[v].src, vecs[v].len);
            load_phase(1'b0);
            run(200);
            chk("vec_beats", out_beats, vecs[v].exp_beats);
            chk("vec_tlast_pos", tlast_at, vecs[v].exp_beats);
            chk("vec_tlast_cnt", tlast_cnt, 1);
            chk("vec_ws_cnt", ws_cnt, vecs[v].exp_ws);
            $display("vec %0d: src=%0d len=%0d out_beats=%0d", v, vecs[v].src, vecs[v].len, out_beats);
        end

        // backpressure 1,0,0,1 through a src0 packet that needs padding
        clear_stats();
        rdy_mode = 2;
        add_pkt(0, 6);
        load_phase(1'b0);
        run(200);
        chk("bp_beats", out_beats, 8);
        chk("bp_tlast_pos", tlast_at, 8);
        $display("backpressure: %0d beats", out_beats);

        // randomized traffic with gaps and random ready
        gaps = 1'b1;
        rdy_mode = 1;
        for (int ph = 0; ph < 6; ph++) begin
            bit pr;
            clear_stats();
            pr = 1'($urandom_range(1));
            for (int s = 0; s < 2; s++) begin
                int np = $urandom_range(1, 4);
                for (int p = 0; p < np; p++) add_pkt(s, $urandom_range(1, 9));
            end
            load_phase(pr);
            run(3000);
            $display("random phase %0d: prio=%0d beats=%0d", ph, pr, out_beats);
        end
        gaps = 1'b0;
        rdy_mode = 0;

        // reset asserted while beat 2 of a src1 packet is on the bus
        clear_stats();
        add_pkt(1, 8);
        load_phase(1'b0);
        n = 0;
        while (q_data[1].size() > 7 && n < 50) begin
            step();
            n++;
        end
        chk("rst_reach_beat2", q_data[1].size(), 7);
        #2;
        rst = 1'b1;
        #1;
        check_reset();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        clear_stats();
        add_pkt(0, 4);
        load_phase(1'b0);
        run(100);
        chk("post_rst_beats", out_beats, 4);
        chk("post_rst_tlast_pos", tlast_at, 4);
        chk("post_rst_ws", ws_cnt, 1);
        $display("reset mid-packet: %0d beats after reset", out_beats);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/psys_stream_arbiter.md
# psys_stream_arbiter

Packet-level arbiter that shares the 1536-bit to 6144-bit width packer between the weight stream (src0) and the activation stream (src1). A grant is held for a whole packet, up to and including its tlast beat. Every forwarded packet is forced to a multiple of 4 input beats: short packets get zero beats appended, so the packer's 4-beat groups never straddle two sources. The block sits directly upstream of the packer. It also generates the packer's `weight_switch` input.

## Interface
- `DATA_W`, default 1536: beat width; fixed by the packer input.
- `GROUP`, default 4: beats per packer output word; must be a power of two.
- `CNT_W`, default 16: width of the per-source packet counters.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s0_axis_tdata` in DATA_W: weight stream data.
- `s0_axis_tvalid` in 1: weight stream valid.
- `s0_axis_tready` out 1: weight stream ready.
- `s0_axis_tlast` in 1: weight stream last beat.
- `s1_axis_tdata` in DATA_W: activation stream data.
- `s1_axis_tvalid` in 1: activation stream valid.
- `s1_axis_tready` out 1: activation stream ready.
- `s1_axis_tlast` in 1: activation stream last beat.
- `m_axis_tdata` out DATA_W: data to the packer.
- `m_axis_tvalid` out 1: valid to the packer.
- `m_axis_tready` in 1: ready from the packer.
- `m_axis_tlast` out 1: last beat to the packer.
- `weight_switch` out 1: high on the first beat of every src0 packet.
- `wgt_prio` in 1: 1 means src0 wins every contention; 0 means round-robin. Sampled only in IDLE.
- `grant_src` out 1: source currently granted (0 = weight, 1 = activation). Valid in PASS and PAD.
- `pad_err` out 1: sticky. Set when any padding occurs. Cleared only by reset.
- `pkt_cnt0` out CNT_W: count of completed src0 packets. Wraps modulo 2^CNT_W.
- `pkt_cnt1` out CNT_W: count of completed src1 packets. Wraps modulo 2^CNT_W.

## Operation
- State machine: IDLE, PASS, PAD. Reset state is IDLE.
- IDLE:
  - If no source has tvalid, stay in IDLE.
  - If exactly one source has tvalid, grant it.
  - If both have tvalid and `wgt_prio` = 1, grant src0.
  - If both have tvalid and `wgt_prio` = 0, grant the source that was not granted last. `last_grant` resets to 1, so src0 wins the first contention.
  - On a grant: register `grant_src`, clear `beat_cnt`, go to PASS. No data moves in the IDLE cycle.
- PASS:
  - `m_axis_*` is a combinational mux of the granted source.
  - The granted source's tready equals `m_axis_tready`. The other source's tready is 0.
  - A beat transfers when `m_axis_tvalid` and `m_axis_tready` are both high. Each transfer increments `beat_cnt` (modulo GROUP).
  - On transfer of a source tlast with `beat_cnt` = GROUP-1: `m_axis_tlast` = 1, increment the source's packet counter, update `last_grant`, go to IDLE.
  - On transfer of a source tlast with `beat_cnt` < GROUP-1: `m_axis_tlast` = 0, set `pad_err`, go to PAD.
- PAD:
  - Both source treadys are 0.
  - Drive `m_axis_tdata` = 0 and `m_axis_tvalid` = 1.
  - `m_axis_tlast` = 1 only when `beat_cnt` = GROUP-1.
  - On the transfer with `beat_cnt` = GROUP-1: increment the packet counter, update `last_grant`, go to IDLE.
- `weight_switch` = 1 when state is PASS, `grant_src` = 0 and `beat_cnt` = 0 and this is the packet's first beat. A `first` flag is set on grant and cleared on the first transfer.
- A tlast on the first beat is legal: that packet is 1 data beat followed by GROUP-1 pad beats.

## Timing
- Reset values:
  - All source treadys 0.
  - `m_axis_tvalid`, `m_axis_tlast` 0.
  - `m_axis_tdata` 0.
  - `weight_switch` 0, `grant_src` 0, `pad_err` 0, both packet counters 0.
- Latency:
  - Data path in PASS: 0 cycles (combinational).
  - Arbitration: 1 bubble cycle (IDLE) between packets.
- Backpressure:
  - In PASS, a stall of `m_axis_tready` stalls the granted source with no loss.
  - In PAD, the output holds its zero beat until `m_axis_tready`.
- Simultaneous events: a tvalid arriving on the other source during PASS or PAD is ignored until the next IDLE.
- Reset mid-packet: the block returns to IDLE immediately. The partial group already in the packer is not flushed; the packer shares the same reset.
- AXI-Stream rule: `m_axis_tvalid` never drops without a transfer in PAD. In PASS it follows the source.

## Structure
- Shared package `psys_route_pkg`:
  - state enum `{IDLE, PASS, PAD}`;
  - constants `BEAT_W = 1536`, `GROUP = 4`;
  - source IDs `SRC_WGT = 0`, `SRC_ACT = 1`.
- The design is a single module. No sub-module is needed; the grant logic is small enough to stay inline.

## Test plan
- **Single source:** src0 sends 8 beats with tlast on beat 8 and `m_axis_tready` = 1.
  - Output: 8 beats, `m_axis_tlast` on beat 8 only, `weight_switch` on beat 1 only.
  - End state: `pkt_cnt0` = 1, `pad_err` = 0.
- **Padding:** src1 sends 5 beats with tlast.
  - Output: 5 data beats, then 3 zero beats. `m_axis_tlast` on beat 8, never on beat 5.
  - End state: `pad_err` = 1, `pkt_cnt1` = 1.
- **Contention, round-robin:** both sources hold 4-beat packets continuously, `wgt_prio` = 0.
  - Grant order: 0, 1, 0, 1.
  - Exactly 1 IDLE cycle between packets.
- **Contention, weight priority:** same stimulus with `wgt_prio` = 1.
  - Only src0 packets are forwarded.
  - `s1_axis_tready` stays 0 throughout.
- **Backpressure:** during a src0 PASS, toggle `m_axis_tready` 1,0,0,1.
  - Data is held stable while stalled; no beat is duplicated or dropped; `s0_axis_tready` mirrors `m_axis_tready`.
  - Repeat during PAD: the zero beat is held until `m_axis_tready` returns.
- **Reset mid-packet:** assert `rst` on beat 2 of a src1 packet.
  - All outputs return to their reset values asynchronously.
  - After `rst` falls, a fresh src0 packet is granted in IDLE with `beat_cnt` = 0.
